// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions.
// Load/store size codes follow the funct3 encoding.
package riscv_pkg;

  localparam logic [2:0] LDST_B  = 3'b000;
  localparam logic [2:0] LDST_H  = 3'b001;
  localparam logic [2:0] LDST_W  = 3'b010;
  localparam logic [2:0] LDST_BU = 3'b100;
  localparam logic [2:0] LDST_HU = 3'b101;

endpackage

// File: rtl/riscv_lsu_ma_if.sv
// Core-side and memory-side bundle of the multi-beat load/store unit.
// core_misalign_o exists only when LSU_MISALIGN_EN is undefined.
interface riscv_lsu_ma_if #(
  parameter int DW = 32,
  parameter int AW = 32
);

  logic          core_req_i;
  logic          core_we_i;
  logic [2:0]    core_size_i;
  logic [AW-1:0] core_addr_i;
  logic [31:0]   core_wd_i;
  logic [31:0]   core_rd_o;
  logic          core_stall_o;
`ifndef LSU_MISALIGN_EN
  logic          core_misalign_o;
`endif

  logic            mem_req_o;
  logic            mem_we_o;
  logic [DW/8-1:0] mem_be_o;
  logic [AW-1:0]   mem_addr_o;
  logic [DW-1:0]   mem_wd_o;
  logic [DW-1:0]   mem_rd_i;
  logic            mem_ready_i;

  modport slave (
    input  core_req_i, core_we_i, core_size_i,
    input  core_addr_i, core_wd_i,
    input  mem_rd_i, mem_ready_i,
    output core_rd_o, core_stall_o,
    output mem_req_o, mem_we_o, mem_be_o,
    output mem_addr_o, mem_wd_o
`ifndef LSU_MISALIGN_EN
    , output core_misalign_o
`endif
  );

  modport master (
    output core_req_i, core_we_i, core_size_i,
    output core_addr_i, core_wd_i,
    output mem_rd_i, mem_ready_i,
    input  core_rd_o, core_stall_o,
    input  mem_req_o, mem_we_o, mem_be_o,
    input  mem_addr_o, mem_wd_o
`ifndef LSU_MISALIGN_EN
    , input core_misalign_o
`endif
  );

endinterface

// File: rtl/riscv_lsu_ma.sv
// Multi-beat load/store unit; LSU_MISALIGN_EN enables split
// accesses over two bus beats, otherwise they are flagged.
module riscv_lsu_ma
  import riscv_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 32
) (
  input logic           clk_i,
  input logic           rst_ni,
  riscv_lsu_ma_if.slave bus
);

  localparam int BW = DW / 8;
  localparam int OW = $clog2(BW);

`ifdef LSU_MISALIGN_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    DONE  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    DONE  = 2'd3
  } state_t;
`endif

  function automatic logic [2:0] nb_of(
    input logic [2:0] s
  );
    logic [2:0] n;
    unique case (1'b1)
      (s == LDST_B) || (s == LDST_BU): n = 3'd1;
      (s == LDST_H) || (s == LDST_HU): n = 3'd2;
      default:                         n = 3'd4;
    endcase
    return n;
  endfunction

  function automatic logic is_split(
    input logic [2:0]    s,
    input logic [OW-1:0] off
  );
    logic [OW+1:0] sum;
    sum = {2'b00, off} + {{(OW-1){1'b0}}, nb_of(s)};
    return sum > (OW+2)'(BW);
  endfunction

  // Lane mask for both beats; upper half is the spill-over beat.
  function automatic logic [BW-1:0] be_of(
    input logic [2:0]    s,
    input logic [OW-1:0] off,
    input logic          hi
  );
    logic [2*BW-1:0] m;
    logic [2:0]      n;
    n = nb_of(s);
    m = '0;
    m[3:0] = (n == 3'd1) ? 4'h1 :
             (n == 3'd2) ? 4'h3 : 4'hF;
    m = m << off;
    return hi ? m[2*BW-1:BW] : m[BW-1:0];
  endfunction

  function automatic logic [DW-1:0] wd_of(
    input logic [31:0]   wd,
    input logic [OW-1:0] off,
    input logic          hi
  );
    logic [2*DW-1:0] w;
    w = '0;
    w[31:0] = wd;
    w = w << {off, 3'b000};
    return hi ? w[2*DW-1:DW] : w[DW-1:0];
  endfunction

  function automatic logic [31:0] load_of(
    input logic [2*DW-1:0] pair,
    input logic [2:0]      s,
    input logic [OW-1:0]   off
  );
    logic [2*DW-1:0] sh;
    logic [31:0]     r;
    sh = pair >> {off, 3'b000};
    unique case (1'b1)
      s == LDST_B:  r = {{24{sh[7]}}, sh[7:0]};
      s == LDST_BU: r = {24'h0, sh[7:0]};
      s == LDST_H:  r = {{16{sh[15]}}, sh[15:0]};
      s == LDST_HU: r = {16'h0, sh[15:0]};
      default:      r = sh[31:0];
    endcase
    return r;
  endfunction

  state_t        state;
  logic          we_q;
  logic [2:0]    size_q;
  logic [OW-1:0] off_q;
  logic [DW-1:0] lo_q;
`ifdef LSU_MISALIGN_EN
  logic [31:0]   wd_q;
  logic [DW-1:0] hi_q;
  logic          split_q;
`else
  logic          mis_q;
  logic          split_in;
`endif

  logic          req_q;
  logic          mwe_q;
  logic [BW-1:0] be_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] mwd_q;

  logic [OW-1:0]   off_in;
  logic [AW-1:0]   base_in;
  logic [2*DW-1:0] pair;
  logic            stall;

  assign off_in  = bus.core_addr_i[OW-1:0];
  assign base_in = {bus.core_addr_i[AW-1:OW], {OW{1'b0}}};

`ifdef LSU_MISALIGN_EN
  assign split_q = is_split(size_q, off_q);
  assign pair    = {hi_q, lo_q};
`else
  assign split_in = is_split(bus.core_size_i, off_in);
  assign pair     = {{DW{1'b0}}, lo_q};
`endif

  always_comb begin
    stall = 1'b0;
    unique case (state)
      IDLE:    stall = bus.core_req_i;
      DONE:    stall = 1'b0;
      default: stall = 1'b1;
    endcase
  end

  // Reset must drop the stall at once, even with a request held.
  assign bus.core_stall_o = rst_ni & stall;

`ifdef LSU_MISALIGN_EN
  assign bus.core_rd_o =
    (state == DONE && !we_q) ?
      load_of(pair, size_q, off_q) : '0;
`else
  assign bus.core_rd_o =
    (state == DONE && !we_q && !mis_q) ?
      load_of(pair, size_q, off_q) : '0;
  assign bus.core_misalign_o = mis_q;
`endif

  assign bus.mem_req_o  = req_q;
  assign bus.mem_we_o   = mwe_q;
  assign bus.mem_be_o   = be_q;
  assign bus.mem_addr_o = addr_q;
  assign bus.mem_wd_o   = mwd_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= IDLE;
      we_q   <= 1'b0;
      size_q <= '0;
      off_q  <= '0;
      lo_q   <= '0;
`ifdef LSU_MISALIGN_EN
      wd_q   <= '0;
      hi_q   <= '0;
`else
      mis_q  <= 1'b0;
`endif
      req_q  <= 1'b0;
      mwe_q  <= 1'b0;
      be_q   <= '0;
      addr_q <= '0;
      mwd_q  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.core_req_i) begin
            we_q   <= bus.core_we_i;
            size_q <= bus.core_size_i;
            off_q  <= off_in;
`ifdef LSU_MISALIGN_EN
            wd_q   <= bus.core_wd_i;
`else
            if (split_in) begin
              state <= DONE;
              mis_q <= 1'b1;
            end else
`endif
            begin
              state  <= BEAT0;
              req_q  <= 1'b1;
              mwe_q  <= bus.core_we_i;
              addr_q <= base_in;
              be_q   <= be_of(bus.core_size_i,
                              off_in, 1'b0);
              mwd_q  <= wd_of(bus.core_wd_i,
                              off_in, 1'b0);
            end
          end
        end
        BEAT0: begin
          if (bus.mem_ready_i) begin
            lo_q <= bus.mem_rd_i;
`ifdef LSU_MISALIGN_EN
            if (split_q) begin
              state  <= BEAT1;
              addr_q <= addr_q + AW'(BW);
              be_q   <= be_of(size_q, off_q, 1'b1);
              mwd_q  <= wd_of(wd_q, off_q, 1'b1);
            end else
`endif
            begin
              state <= DONE;
              req_q <= 1'b0;
              mwe_q <= 1'b0;
              be_q  <= '0;
            end
          end
        end
`ifdef LSU_MISALIGN_EN
        BEAT1: begin
          if (bus.mem_ready_i) begin
            hi_q  <= bus.mem_rd_i;
            state <= DONE;
            req_q <= 1'b0;
            mwe_q <= 1'b0;
            be_q  <= '0;
          end
        end
`endif
        DONE: begin
          state <= IDLE;
`ifndef LSU_MISALIGN_EN
          mis_q <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_lsu_ma.sv
// Bench for riscv_lsu_ma: directed cases plus random accesses
// checked against a byte-array reference memory.
module tb_riscv_lsu_ma;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  riscv_lsu_ma_if #(.DW(32), .AW(32)) m32 ();
  riscv_lsu_ma_if #(.DW(64), .AW(32)) m64 ();

  riscv_lsu_ma #(.DW(32), .AW(32)) dut32 (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (m32.slave)
  );

  riscv_lsu_ma #(.DW(64), .AW(32)) dut64 (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (m64.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  bus_mem [256];
  logic [7:0]  ref_mem [256];
  int          rdy_mode = 0;
  int          beats;
  int          mis_cyc;
  logic [31:0] b_addr [4];
  logic [3:0]  b_be   [4];
  logic [31:0] b_wd   [4];
  int          beats64;
  logic [31:0] b64_addr [2];
  logic [7:0]  b64_be   [2];
  logic [7:0]  ra;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Memory side: responses prepared on the falling edge.
  always @(negedge clk) begin
    ra = m32.mem_addr_o[7:0];
    m32.mem_rd_i = {bus_mem[ra+8'd3], bus_mem[ra+8'd2],
                    bus_mem[ra+8'd1], bus_mem[ra]};
    m32.mem_ready_i = (rdy_mode == 0) ? 1'b1 :
                      (rdy_mode == 1) ?
                        ($urandom_range(0, 2) != 0) : 1'b0;
    m64.mem_ready_i = 1'b1;
    m64.mem_rd_i = (m64.mem_addr_o == 32'h0) ?
                   64'h7F : 64'hAB00_0000_0000_0000;
`ifndef LSU_MISALIGN_EN
    if (m32.core_misalign_o === 1'b1) mis_cyc++;
`endif
  end

  always @(posedge clk) begin
    if (rst_n === 1'b1 && m32.mem_req_o === 1'b1 &&
        m32.mem_ready_i === 1'b1) begin
      if (beats < 4) begin
        b_addr[beats] = m32.mem_addr_o;
        b_be[beats]   = m32.mem_be_o;
        b_wd[beats]   = m32.mem_wd_o;
      end
      if (m32.mem_we_o === 1'b1)
        for (int i = 0; i < 4; i++)
          if (m32.mem_be_o[i])
            bus_mem[8'(m32.mem_addr_o + 32'(i))] =
              m32.mem_wd_o[8*i +: 8];
      beats++;
    end
    if (rst_n === 1'b1 && m64.mem_req_o === 1'b1 &&
        m64.mem_ready_i === 1'b1) begin
      if (beats64 < 2) begin
        b64_addr[beats64] = m64.mem_addr_o;
        b64_be[beats64]   = m64.mem_be_o;
      end
      beats64++;
    end
  end

  function automatic int nb_of(input logic [2:0] s);
    if (s == LDST_B || s == LDST_BU) return 1;
    if (s == LDST_H || s == LDST_HU) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ref_load(
    input logic [2:0] s, input logic [31:0] ad);
    logic [31:0] v;
    int nb;
    nb = nb_of(s);
    v = '0;
    for (int i = 0; i < nb; i++)
      v[8*i +: 8] = ref_mem[8'(ad + 32'(i))];
    if (s == LDST_B && v[7])  v[31:8]  = '1;
    if (s == LDST_H && v[15]) v[31:16] = '1;
    return v;
  endfunction

  task automatic access(input logic we, input logic [2:0] sz,
                        input logic [31:0] ad,
                        input logic [31:0] wd,
                        output logic [31:0] rd,
                        output int lat, output logic leak);
    int n;
    beats = 0;
    mis_cyc = 0;
    leak = 1'b0;
    @(negedge clk);
    m32.core_req_i  = 1'b1;
    m32.core_we_i   = we;
    m32.core_size_i = sz;
    m32.core_addr_i = ad;
    m32.core_wd_i   = wd;
    n = 1;
    #1;
    while (m32.core_stall_o === 1'b1 && n < 60) begin
      if (m32.core_rd_o !== 32'h0) leak = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    chk("no_timeout", 64'(n < 60), 64'd1);
    lat = n;
    rd = m32.core_rd_o;
    m32.core_req_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic check_acc(input string tag, input logic we,
                           input logic [2:0] sz,
                           input logic [31:0] ad,
                           input logic [31:0] wd,
                           output logic [31:0] rd);
    int nb, lat;
    bit sp;
    logic leak;
    logic [31:0] exp_rd, wb, wr;
    nb = nb_of(sz);
    sp = (int'(ad % 4) + nb) > 4;
    exp_rd = ref_load(sz, ad);
`ifndef LSU_MISALIGN_EN
    if (sp) exp_rd = 32'h0;
`endif
    access(we, sz, ad, wd, rd, lat, leak);
    if (!we) chk({tag, " rd"}, 64'(rd), 64'(exp_rd));
    chk({tag, " rd_early"}, 64'(leak), 64'd0);
`ifdef LSU_MISALIGN_EN
    chk({tag, " beats"}, 64'(beats), sp ? 64'd2 : 64'd1);
    if (rdy_mode == 0)
      chk({tag, " latency"}, 64'(lat), sp ? 64'd4 : 64'd3);
    if (we)
      for (int i = 0; i < nb; i++)
        ref_mem[8'(ad + 32'(i))] = wd[8*i +: 8];
`else
    chk({tag, " beats"}, 64'(beats), sp ? 64'd0 : 64'd1);
    chk({tag, " misalign"}, 64'(mis_cyc), sp ? 64'd1 : 64'd0);
    if (rdy_mode == 0)
      chk({tag, " latency"}, 64'(lat), sp ? 64'd2 : 64'd3);
    if (we && !sp)
      for (int i = 0; i < nb; i++)
        ref_mem[8'(ad + 32'(i))] = wd[8*i +: 8];
`endif
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        wb[8*i +: 8] = bus_mem[8'(ad + 32'(i))];
        wr[8*i +: 8] = ref_mem[8'(ad + 32'(i))];
      end
      chk({tag, " mem"}, 64'(wb), 64'(wr));
    end
  endtask

  logic [2:0]  szs [8] = '{LDST_B, LDST_H, LDST_W, LDST_BU,
                           LDST_HU, 3'b011, 3'b110, 3'b111};
  logic [31:0] rd, a0, ad;
  logic [3:0]  be0;
  logic        stable, we;
  logic [2:0]  sz;
  int          n;

  initial begin
    for (int i = 0; i < 256; i++) begin
      bus_mem[i] = 8'($urandom);
      ref_mem[i] = bus_mem[i];
    end
    m32.core_req_i = 1'b1;
    m32.core_we_i = 1'b0;
    m32.core_size_i = LDST_W;
    m32.core_addr_i = 32'h0;
    m32.core_wd_i = 32'h0;
    m64.core_req_i = 1'b0;
    m64.core_we_i = 1'b0;
    m64.core_size_i = LDST_W;
    m64.core_addr_i = 32'h0;
    m64.core_wd_i = 32'h0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst stall", 64'(m32.core_stall_o), 64'd0);
    chk("rst req", 64'(m32.mem_req_o), 64'd0);
    chk("rst we", 64'(m32.mem_we_o), 64'd0);
    chk("rst be", 64'(m32.mem_be_o), 64'd0);
    chk("rst rd", 64'(m32.core_rd_o), 64'd0);
    m32.core_req_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Word load, aligned (0x100 maps to index 0 of the model).
    {ref_mem[0], ref_mem[1], ref_mem[2], ref_mem[3]} =
      {8'hEF, 8'hBE, 8'hAD, 8'hDE};
    {bus_mem[0], bus_mem[1], bus_mem[2], bus_mem[3]} =
      {8'hEF, 8'hBE, 8'hAD, 8'hDE};
    check_acc("lw100", 1'b0, LDST_W, 32'h100, 32'h0, rd);
    chk("lw100 value", 64'(rd), 64'hDEADBEEF);
    chk("lw100 be", 64'(b_be[0]), 64'hF);
    chk("lw100 addr", 64'(b_addr[0]), 64'h100);

    ref_mem[8'h03] = 8'h80;
    bus_mem[8'h03] = 8'h80;
    check_acc("lb103", 1'b0, LDST_B, 32'h103, 32'h0, rd);
    chk("lb103 value", 64'(rd), 64'hFFFFFF80);
    chk("lb103 be", 64'(b_be[0]), 64'h8);
    check_acc("lbu103", 1'b0, LDST_BU, 32'h103, 32'h0, rd);
    chk("lbu103 value", 64'(rd), 64'h80);

`ifdef LSU_MISALIGN_EN
    check_acc("sw0fe", 1'b1, LDST_W, 32'h0FE,
              32'h11223344, rd);
    chk("sw0fe b0 addr", 64'(b_addr[0]), 64'h0FC);
    chk("sw0fe b0 be", 64'(b_be[0]), 64'hC);
    chk("sw0fe b0 wd", 64'(b_wd[0]), 64'h33440000);
    chk("sw0fe b1 addr", 64'(b_addr[1]), 64'h100);
    chk("sw0fe b1 be", 64'(b_be[1]), 64'h3);
    chk("sw0fe b1 wd", 64'(b_wd[1]), 64'h00001122);
`else
    check_acc("lw102", 1'b0, LDST_W, 32'h102, 32'h0, rd);
    chk("lw102 value", 64'(rd), 64'h0);
`endif

    // 64-bit bus, halfword straddling the top of memory.
    beats64 = 0;
    @(negedge clk);
    m64.core_req_i  = 1'b1;
    m64.core_size_i = LDST_H;
    m64.core_addr_i = 32'hFFFFFFFF;
    n = 1;
    #1;
    while (m64.core_stall_o === 1'b1 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("lh64 no_timeout", 64'(n < 60), 64'd1);
    rd = m64.core_rd_o;
    m64.core_req_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
`ifdef LSU_MISALIGN_EN
    chk("lh64 value", 64'(rd), 64'h00007FAB);
    chk("lh64 beats", 64'(beats64), 64'd2);
    chk("lh64 b0 addr", 64'(b64_addr[0]), 64'hFFFFFFF8);
    chk("lh64 b0 be", 64'(b64_be[0]), 64'h80);
    chk("lh64 b1 addr", 64'(b64_addr[1]), 64'h0);
    chk("lh64 b1 be", 64'(b64_be[1]), 64'h01);
`else
    chk("lh64 value", 64'(rd), 64'h0);
    chk("lh64 beats", 64'(beats64), 64'd0);
`endif

    for (int k = 0; k < 80; k++) begin
      rdy_mode = $urandom_range(0, 1);
      we = 1'($urandom_range(0, 1));
      sz = szs[$urandom_range(0, 7)];
      ad = ($urandom_range(0, 3) == 0) ?
           {24'hFFFFFF, 8'($urandom)} :
           {24'h0, 8'($urandom)};
      check_acc($sformatf("rnd%0d", k), we, sz, ad,
                $urandom, rd);
    end

    // Bus stuck during the first beat, then reset mid-access.
    rdy_mode = 2;
    @(negedge clk);
    m32.core_req_i  = 1'b1;
    m32.core_we_i   = 1'b0;
    m32.core_size_i = LDST_W;
    m32.core_addr_i = 32'h40;
    @(posedge clk);
    #1;
    a0 = m32.mem_addr_o;
    be0 = m32.mem_be_o;
    stable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      if (m32.mem_addr_o !== a0 || m32.mem_be_o !== be0 ||
          m32.core_stall_o !== 1'b1 ||
          m32.mem_req_o !== 1'b1)
        stable = 1'b0;
    end
    chk("wait stable", 64'(stable), 64'd1);
    chk("wait addr", 64'(a0), 64'h40);
    chk("wait be", 64'(be0), 64'hF);
    rst_n = 1'b0;
    #1;
    chk("midrst req", 64'(m32.mem_req_o), 64'd0);
    chk("midrst stall", 64'(m32.core_stall_o), 64'd0);
    chk("midrst be", 64'(m32.mem_be_o), 64'd0);
    chk("midrst we", 64'(m32.mem_we_o), 64'd0);
    m32.core_req_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rdy_mode = 0;
    check_acc("post_rst", 1'b0, LDST_W, 32'h44, 32'h0, rd);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
